cic_decim_mc: RTL and testbench

Parametrised multi-channel CIC decimator for PDM microphone inputs in the uDMA I2S/PDM receive path. Each channel converts a 1-bit PDM stream into signed PCM words through STAGES integrators, a shared decimation counter and STAGES combs. Outputs pass through a programmable shift, optional rounding and saturation. All channels share one valid/ready output register that feeds the uDMA RX channel logic.

---
 rtl/cic_pkg.sv | 23 ++
 rtl/cic_decim_mc_if.sv | 12 +
 rtl/cic_decim_mc_chan.sv | 80 ++++++++
 rtl/cic_decim_mc.sv | 91 +++++++++
 tb/tb_cic_decim_mc.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/cic_pkg.sv
// Shared defaults, accumulator container type and output saturation helper for
// the multi-channel CIC decimator.
package cic_pkg;
  localparam int STAGES_DEF    = 5;
  localparam int ACC_WIDTH_DEF = 52;
  localparam int OUT_WIDTH_DEF = 16;
  localparam int CHANNELS_DEF  = 2;
  localparam int DEC_WIDTH_DEF = 10;
  localparam int ACC_MAX       = 64;

  // Container for the accumulator; the datapath width is sign-extended into it.
  typedef logic signed [ACC_MAX-1:0] acc_t;

  function automatic acc_t sat_shift(acc_t value, logic [7:0] shift, int out_width);
    acc_t s, hi, lo;
    s  = value >>> shift;
    hi = (acc_t'(1) <<< (out_width - 1)) - acc_t'(1);
    lo = -(acc_t'(1) <<< (out_width - 1));
    if (s > hi)      s = hi;
    else if (s < lo) s = lo;
    return s;
  endfunction
endpackage

// File: rtl/cic_decim_mc_if.sv
// PCM output bus of the CIC decimator: word, valid and ready.
interface cic_decim_mc_if import cic_pkg::*; #(
  parameter int CHANNELS  = CHANNELS_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF
) ();
  logic [CHANNELS*OUT_WIDTH-1:0] data_o;
  logic                          data_valid_o;
  logic                          data_ready_i;

  modport master (output data_o, output data_valid_o, input  data_ready_i);
  modport slave  (input  data_o, input  data_valid_o, output data_ready_i);
endinterface

// File: rtl/cic_decim_mc_chan.sv
// One CIC channel: integrator chain, comb chain and shift/round/saturate logic.
// Rounding is added only when CIC_ROUND_EN is defined.
module cic_chan import cic_pkg::*; #(
  parameter int STAGES      = STAGES_DEF,
  parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
  parameter int OUT_WIDTH   = OUT_WIDTH_DEF,
  parameter int SHIFT_WIDTH = $clog2(ACC_WIDTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   en_int_i,
  input  logic                   en_comb_i,
  input  logic                   bit_i,
  input  logic [SHIFT_WIDTH-1:0] shift_i,
  output logic [OUT_WIDTH-1:0]   pcm_o
);
  typedef logic signed [ACC_WIDTH-1:0] word_t;

  word_t int_q [STAGES];
  word_t int_d [STAGES];
  word_t comb_q[STAGES];
  word_t comb_d[STAGES];
  word_t dly_q [STAGES];
  word_t dly_d [STAGES];
  word_t x;
  acc_t  v;

  assign x = bit_i ? word_t'(1) : '1;

  always_comb begin
    int_d  = int_q;
    comb_d = comb_q;
    dly_d  = dly_q;
    if (en_int_i) begin
      int_d[0] = int_q[0] + x;
      for (int s = 1; s < STAGES; s++) int_d[s] = int_q[s] + int_q[s-1];
    end
    // Combs form a registered pipeline, one decimated sample per stage.
    if (en_comb_i) begin
      dly_d[0]  = int_q[STAGES-1];
      comb_d[0] = int_q[STAGES-1] - dly_q[0];
      for (int s = 1; s < STAGES; s++) begin
        dly_d[s]  = comb_q[s-1];
        comb_d[s] = comb_q[s-1] - dly_q[s];
      end
    end
    if (clr_i) begin
      for (int s = 0; s < STAGES; s++) begin
        int_d[s]  = '0;
        comb_d[s] = '0;
        dly_d[s]  = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < STAGES; s++) begin
        int_q[s]  <= '0;
        comb_q[s] <= '0;
        dly_q[s]  <= '0;
      end
    end else begin
      int_q  <= int_d;
      comb_q <= comb_d;
      dly_q  <= dly_d;
    end
  end

`ifdef CIC_ROUND_EN
  acc_t rnd;
  assign rnd = (shift_i != '0) ? (acc_t'(1) <<< (shift_i - SHIFT_WIDTH'(1))) : '0;
  assign v   = acc_t'(comb_q[STAGES-1]) + rnd;
`else
  assign v   = acc_t'(comb_q[STAGES-1]);
`endif

  assign pcm_o = OUT_WIDTH'(sat_shift(v, 8'(shift_i), OUT_WIDTH));
endmodule

// File: rtl/cic_decim_mc.sv
// Multi-channel PDM CIC decimator: shared decimation counter, per-channel filters,
// single valid/ready output register with sticky overrun. CIC_ROUND_EN enables rounding.
module cic_decim_mc import cic_pkg::*; #(
  parameter int STAGES      = STAGES_DEF,
  parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
  parameter int OUT_WIDTH   = OUT_WIDTH_DEF,
  parameter int CHANNELS    = CHANNELS_DEF,
  parameter int DEC_WIDTH   = DEC_WIDTH_DEF,
  parameter int SHIFT_WIDTH = $clog2(ACC_WIDTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cfg_update_i,
  input  logic [DEC_WIDTH-1:0]   cfg_decimation_i,
  input  logic [SHIFT_WIDTH-1:0] cfg_shift_i,
  input  logic [CHANNELS-1:0]    data_i,
  input  logic                   data_valid_i,
  cic_decim_mc_if.master         out_if,
  output logic                   overrun_o
);
  logic [DEC_WIDTH-1:0]              cnt_q, cnt_d;
  logic                              strobe_q, strobe_d;
  logic                              load_q, load_d;
  logic                              valid_q, valid_d;
  logic                              ovr_q, ovr_d;
  logic [CHANNELS*OUT_WIDTH-1:0]     data_q, data_d;
  logic [CHANNELS-1:0][OUT_WIDTH-1:0] pcm;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    cic_chan #(
      .STAGES(STAGES), .ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH), .SHIFT_WIDTH(SHIFT_WIDTH)
    ) u_chan (
      .clk_i(clk_i), .rst_i(rst_i), .clr_i(cfg_update_i),
      .en_int_i(data_valid_i), .en_comb_i(strobe_q),
      .bit_i(data_i[c]), .shift_i(cfg_shift_i), .pcm_o(pcm[c])
    );
  end

  always_comb begin
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    load_d   = strobe_q;   // combs settle during the strobe cycle, word is ready one later
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    data_d   = data_q;
    if (valid_q && out_if.data_ready_i) valid_d = 1'b0;
    if (load_q) begin
      data_d  = pcm;
      valid_d = 1'b1;
      if (valid_q && !out_if.data_ready_i) ovr_d = 1'b1;
    end
    if (data_valid_i) begin
      if (cnt_q == cfg_decimation_i) begin
        cnt_d    = '0;
        strobe_d = 1'b1;
      end else begin
        cnt_d = cnt_q + DEC_WIDTH'(1);
      end
    end
    if (cfg_update_i) begin
      cnt_d    = '0;
      strobe_d = 1'b0;
      load_d   = 1'b0;
      valid_d  = 1'b0;
      ovr_d    = 1'b0;
      data_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      strobe_q <= 1'b0;
      load_q   <= 1'b0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
      load_q   <= load_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
      data_q   <= data_d;
    end
  end

  assign out_if.data_o       = data_q;
  assign out_if.data_valid_o = valid_q;
  assign overrun_o           = ovr_q;
endmodule

// File: tb/tb_cic_decim_mc.sv
// Scoreboard bench for cic_decim_mc: directed constant-input cases checked by a
// monitor on accepted words, plus direct handshake, counter and clear checks.
module tb_cic_decim_mc;
  localparam int CH = 2, OW = 16, DW = 10, SW = 6;

  logic          clk = 1'b0, rst = 1'b1, cfg_update = 1'b0, din_v = 1'b0, ovr;
  logic [DW-1:0] dec = '0;
  logic [SW-1:0] sh = '0;
  logic [CH-1:0] din = '0;

  cic_decim_mc_if #(.CHANNELS(CH), .OUT_WIDTH(OW)) oif ();

  cic_decim_mc #(.STAGES(5), .ACC_WIDTH(52), .OUT_WIDTH(OW), .CHANNELS(CH), .DEC_WIDTH(DW),
                 .SHIFT_WIDTH(SW)) dut (
    .clk_i(clk), .rst_i(rst), .cfg_update_i(cfg_update), .cfg_decimation_i(dec),
    .cfg_shift_i(sh), .data_i(din), .data_valid_i(din_v), .out_if(oif), .overrun_o(ovr)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic chk(string name, logic signed [63:0] act, logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct { bit chk; int e0; int e1; string name; } exp_t;
  exp_t exp_q[$];
  bit   mon_en = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && oif.data_valid_o && oif.data_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_word: got unexpected word %h", oif.data_o);
      end else begin
        e = exp_q.pop_front();
        if (e.chk) begin
          chk({e.name, "_ch0"}, $signed(oif.data_o[15:0]), e.e0);
          chk({e.name, "_ch1"}, $signed(oif.data_o[31:16]), e.e1);
        end
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear(int d, int s);
    dec = DW'(d); sh = SW'(s); din_v = 1'b0; cfg_update = 1'b1;
    tick();
    cfg_update = 1'b0;
  endtask

  // 25 words per case; the first 15 cover the filter transient and are not checked.
  task automatic run_case(string name, int d, int s, int e0, int e1);
    exp_t e;
    clear(d, s);
    oif.data_ready_i = 1'b1; din = 2'b01; mon_en = 1'b1;
    for (int i = 0; i < 25; i++) begin
      e.chk = (i >= 15); e.e0 = e0; e.e1 = e1; e.name = name;
      exp_q.push_back(e);
    end
    din_v = 1'b1;
    tick(25 * (d + 1));
    din_v = 1'b0;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) chk({name, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
    tick(5);
    mon_en = 1'b0;
  endtask

  task automatic clear_test(bit use_rst, string name);
    clear(3, 0);
    oif.data_ready_i = 1'b0; din = 2'b01; din_v = 1'b1;
    tick(14);
    chk({name, "_ovr_pre"}, ovr, 1);
    if (use_rst) rst = 1'b1; else cfg_update = 1'b1;
    tick();
    rst = 1'b0; cfg_update = 1'b0; din_v = 1'b0;
    chk({name, "_valid"}, oif.data_valid_o, 0);
    chk({name, "_ovr"}, ovr, 0);
    chk({name, "_data"}, oif.data_o, 0);
    din_v = 1'b1; tick(3); din_v = 1'b0; tick(6);
    chk({name, "_no_early_word"}, oif.data_valid_o, 0);
    din_v = 1'b1; tick(1); din_v = 1'b0; tick(3);
    chk({name, "_word_after_4"}, oif.data_valid_o, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t[3];
    int n, k;
    oif.data_ready_i = 1'b1;
    rst = 1'b1;
    tick(3);
    chk("rst_valid", oif.data_valid_o, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_data", oif.data_o, 0);
    rst = 1'b0;

    run_case("const_r4", 3, 0, 1024, -1024);
    run_case("const_r4_sh3", 3, 3, 128, -128);
`ifdef CIC_ROUND_EN
    run_case("round_r3", 2, 1, 122, -121);
`else
    run_case("round_r3", 2, 1, 121, -122);
`endif
    run_case("sat_r16", 15, 0, 32767, -32768);

    // Two loads with ready low: last word held, overrun set
    clear(3, 0);
    oif.data_ready_i = 1'b1; din = 2'b01; din_v = 1'b1;
    tick(100);
    oif.data_ready_i = 1'b0;
    tick(12);
    chk("hs_valid", oif.data_valid_o, 1);
    chk("hs_ovr", ovr, 1);
    chk("hs_data_ch0", $signed(oif.data_o[15:0]), 1024);
    chk("hs_data_ch1", $signed(oif.data_o[31:16]), -1024);

    // Ready rises in the same cycle as the next load: no overrun
    clear(3, 0);
    oif.data_ready_i = 1'b0; din_v = 1'b1;
    k = 0;
    while (!oif.data_valid_o && k < 20) begin @(negedge clk); k++; end
    if (k >= 20) chk("hs2_wait", 0, 1);
    tick(3);
    oif.data_ready_i = 1'b1;
    tick(1);
    chk("hs2_ovr", ovr, 0);
    chk("hs2_valid", oif.data_valid_o, 1);
    din_v = 1'b0;

    // One sample every 3rd cycle with R = 4: words 12 cycles apart
    clear(3, 0);
    oif.data_ready_i = 1'b1;
    n = 0;
    for (int c = 0; c < 90 && n < 3; c++) begin
      din_v = (c % 3 == 0);
      @(negedge clk);
      if (oif.data_valid_o) begin t[n] = c; n++; end
      @(posedge clk); #1;
    end
    din_v = 1'b0;
    if (n < 3) chk("cnt_words", n, 3);
    else begin
      chk("cnt_gap1", t[1] - t[0], 12);
      chk("cnt_gap2", t[2] - t[1], 12);
    end

    clear_test(1'b0, "clr_upd");
    clear_test(1'b1, "clr_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
